outer_product_sequencer: RTL

Controller and accumulator for an N x N outer-product matrix multiply, C = sum over k of (column k of A) x (row k of B).
- Fetches A and B from two single-port block ROMs with 1-cycle read latency.
- Latches one column of A and one row of B per rank-1 step, then applies a single-cycle N x N multiply-accumulate update.
- Presents the finished C matrix with a start/busy/done handshake.
- Replaces the free-running address counters and unsequenced outer-product pipeline.

---
 rtl/outer_product_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/outer_product_sequencer.sv
// outer_product_sequencer
//   Sequences an N x N matrix multiply as N rank-1 (outer-product) updates:
//   C = sum_k col_k(A) x row_k(B). A and B are read from two single-port ROMs
//   with a 1-cycle read latency. The result is presented with a start/busy/done
//   handshake.
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : request a run; only looked at while idle
//   busy          : run in progress (first FETCH cycle through DONE)
//   done          : one-cycle pulse in the cycle the result becomes final
//   a_en/a_addr   : A ROM read port; a_dout returns data one cycle later
//   b_en/b_addr   : B ROM read port; b_dout returns data one cycle later
//   result        : C matrix, element (i,j) at [(i*N+j)*ACC_W +: ACC_W]
//   result_valid  : result is final; held until the next run is accepted
module outer_product_sequencer #(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 4,
    parameter int BASE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     a_en,
    output logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_dout,
    output logic                     b_en,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_dout,
    output logic [N*N*ACC_W-1:0]     result,
    output logic                     result_valid
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               k_q, k_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [N-1:0][DATA_W-1:0]       col_a_q, col_a_d;
    logic [N-1:0][DATA_W-1:0]       row_b_q, row_b_d;
    logic [N*N-1:0][ACC_W-1:0]      acc_q, acc_d;
    logic                           rv_q, rv_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           en_q, en_d;
    logic [ADDR_W-1:0]              a_addr_q, a_addr_d;
    logic [ADDR_W-1:0]              b_addr_q, b_addr_d;

    // Full-width unsigned product, then zero-extended or truncated to ACC_W.
    function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0]       p;
        logic [ACC_W+2*DATA_W-1:0] w;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        w = {{ACC_W{1'b0}}, p};
        return w[ACC_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int r, input int c);
        return ADDR_W'(BASE + r * N + c);
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        col_a_d = col_a_q;
        row_b_d = row_b_q;
        acc_d   = acc_q;
        rv_d    = rv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    acc_d   = '0;
                    rv_d    = 1'b0;
                    k_d     = '0;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                // Data for the address issued last cycle arrives now.
                if (idx_q != '0) begin
                    col_a_d[idx_q - 1'b1] = a_dout;
                    row_b_d[idx_q - 1'b1] = b_dout;
                end
                if (idx_q == LAST) state_d = S_WAIT;
                else               idx_d   = idx_q + 1'b1;
            end
            S_WAIT: begin
                col_a_d[N-1] = a_dout;
                row_b_d[N-1] = b_dout;
                state_d      = S_UPDATE;
            end
            S_UPDATE: begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc_d[i*N+j] = acc_q[i*N+j] + mac_term(col_a_q[i], row_b_q[j]);
                    end
                end
                if (k_q == LAST) begin
                    state_d = S_DONE;
                    rv_d    = 1'b1;   // valid rises together with done
                end else begin
                    k_d     = k_q + 1'b1;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        en_d     = (state_d == S_FETCH);
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        if (en_d) begin
            a_addr_d = addr_of(int'(idx_d), int'(k_d));
            b_addr_d = addr_of(int'(k_d), int'(idx_d));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            idx_q    <= '0;
            col_a_q  <= '0;
            row_b_q  <= '0;
            acc_q    <= '0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            col_a_q  <= col_a_d;
            row_b_q  <= row_b_d;
            acc_q    <= acc_d;
            rv_q     <= rv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign a_en         = en_q;
    assign b_en         = en_q;
    assign a_addr       = a_addr_q;
    assign b_addr       = b_addr_q;
    assign result       = acc_q;
    assign result_valid = rv_q;

endmodule
